// File: rtl/duc_iq_receive.sv
// duc_iq_receive
// Receive-side parser for DUC (Tx) I/Q datagrams arriving on a UDP port. It strips
// the 4-byte big-endian sequence number and checks that the numbers are continuous.
// It packs each 6-byte I/Q sample into one 48-bit word for the Tx sample FIFO.
// Sequence errors, short datagrams and FIFO overflows are counted for the status path.
//
// Ports
//   rx_clock        in   1   receive clock, rising edge
//   reset           in   1   synchronous, active-high
//   run             in   1   radio running; low discards everything and forces a resync
//   udp_rx_active   in   1   high for each valid payload byte, contiguous per datagram
//   udp_rx_data     in   8   payload byte
//   to_port         in   16  destination port of the current datagram
//   fifo_full       in   1   Tx sample FIFO full
//   fifo_wrreq      out  1   one-cycle FIFO write strobe
//   fifo_wdata      out  48  {I[23:0], Q[23:0]}, MSB first as received
//   seq_error       out  1   one-cycle pulse on a sequence discontinuity
//   seq_err_count   out  16  saturating count of sequence discontinuities
//   overflow_count  out  16  saturating count of samples dropped on fifo_full
//   short_count     out  16  saturating count of truncated datagrams
//   last_seq        out  32  sequence number of the most recent accepted datagram

module duc_iq_receive #(
  parameter logic [15:0] PORT    = 16'd1029,
  parameter int unsigned SAMPLES = 240
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        run,
  input  logic        udp_rx_active,
  input  logic [7:0]  udp_rx_data,
  input  logic [15:0] to_port,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [47:0] fifo_wdata,
  output logic        seq_error,
  output logic [15:0] seq_err_count,
  output logic [15:0] overflow_count,
  output logic [15:0] short_count,
  output logic [31:0] last_seq
);

  localparam int unsigned SCW     = $clog2(SAMPLES);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEQ     = 2'd1,
    IQ      = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]     byte_no;      // sequence byte index within SEQ
  logic [2:0]     byte_idx;     // byte index within the current I/Q sample
  logic [SCW-1:0] sample_cnt;   // samples completed in this datagram
  logic [23:0]    seq_hi;       // first three sequence bytes, shifted in MSB first
  logic [39:0]    asm_q;        // first five bytes of the sample being assembled
  logic [31:0]    expected_seq;
  logic           seq_valid;

  logic        seq_start_c;
  logic        seq_byte_c;
  logic        seq_done_c;
  logic [31:0] seq_full_c;
  logic        seq_bad_c;
  logic        iq_byte_c;
  logic        sample_done_c;
  logic        last_sample_c;
  logic        write_c;
  logic        drop_c;
  logic        short_c;

  // State register
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; run low overrides everything
  always_comb begin
    state_nx = state;
    if (!run) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (udp_rx_active) begin
            state_nx = (to_port == PORT) ? SEQ : DISCARD;
          end
        end
        SEQ: begin
          if (!udp_rx_active) begin
            state_nx = IDLE;
          end else if (byte_no == 2'd3) begin
            state_nx = IQ;
          end
        end
        IQ: begin
          if (!udp_rx_active) begin
            state_nx = IDLE;
          end else if (last_sample_c) begin
            state_nx = DISCARD;
          end
        end
        DISCARD: begin
          if (!udp_rx_active) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Per-cycle decode of datapath events
  always_comb begin
    seq_start_c   = (state == IDLE) && run && udp_rx_active && (to_port == PORT);
    seq_byte_c    = (state == SEQ) && run && udp_rx_active;
    seq_done_c    = seq_byte_c && (byte_no == 2'd3);
    seq_full_c    = {seq_hi, udp_rx_data};
    seq_bad_c     = seq_done_c && seq_valid && (seq_full_c != expected_seq);
    iq_byte_c     = (state == IQ) && run && udp_rx_active;
    sample_done_c = iq_byte_c && (byte_idx == 3'd5);
    last_sample_c = sample_done_c && (sample_cnt == SCW'(SAMPLES - 1));
    write_c       = sample_done_c && !fifo_full;
    drop_c        = sample_done_c && fifo_full;
    short_c       = run && !udp_rx_active && ((state == SEQ) || (state == IQ));
  end

  // Parsing counters and assembly registers
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      byte_no    <= '0;
      byte_idx   <= '0;
      sample_cnt <= '0;
      seq_hi     <= '0;
      asm_q      <= '0;
    end else begin
      if (seq_start_c) begin
        seq_hi  <= {16'h0000, udp_rx_data};
        byte_no <= 2'd1;
      end else if (seq_byte_c) begin
        seq_hi  <= {seq_hi[15:0], udp_rx_data};
        byte_no <= byte_no + 2'd1;
      end

      if (seq_done_c) begin
        byte_idx   <= '0;
        sample_cnt <= '0;
      end else if (iq_byte_c) begin
        asm_q    <= {asm_q[31:0], udp_rx_data};
        byte_idx <= (byte_idx == 3'd5) ? 3'd0 : byte_idx + 3'd1;
        if (sample_done_c) begin
          sample_cnt <= sample_cnt + SCW'(1);
        end
      end
    end
  end

  // Sequence tracking; run low drops sync so the next datagram is taken as fresh
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      seq_valid     <= 1'b0;
      expected_seq  <= '0;
      last_seq      <= '0;
      seq_error     <= 1'b0;
      seq_err_count <= '0;
    end else begin
      seq_error <= seq_bad_c;
      if (seq_bad_c && (seq_err_count != CNT_MAX)) begin
        seq_err_count <= seq_err_count + 16'd1;
      end
      if (!run) begin
        seq_valid <= 1'b0;
      end else if (seq_done_c) begin
        seq_valid    <= 1'b1;
        last_seq     <= seq_full_c;
        expected_seq <= seq_full_c + 32'd1;
      end
    end
  end

  // FIFO write port and drop/short statistics
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      fifo_wrreq     <= 1'b0;
      fifo_wdata     <= '0;
      overflow_count <= '0;
      short_count    <= '0;
    end else begin
      fifo_wrreq <= write_c;
      if (write_c) begin
        fifo_wdata <= {asm_q, udp_rx_data};
      end
      if (drop_c && (overflow_count != CNT_MAX)) begin
        overflow_count <= overflow_count + 16'd1;
      end
      if (short_c && (short_count != CNT_MAX)) begin
        short_count <= short_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_duc_iq_receive.sv
// Scoreboard bench for duc_iq_receive: the driver queues every 48-bit word it expects
// the parser to write. The monitor pops and compares one queued word per FIFO write.

module tb_duc_iq_receive;

  localparam int unsigned SAMPLES = 240;
  localparam logic [15:0] PORT    = 16'd1029;
  localparam int          FULL_LEN = 4 + 6 * SAMPLES;

  logic        rx_clock;
  logic        reset;
  logic        run;
  logic        udp_rx_active;
  logic [7:0]  udp_rx_data;
  logic [15:0] to_port;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [47:0] fifo_wdata;
  logic        seq_error;
  logic [15:0] seq_err_count;
  logic [15:0] overflow_count;
  logic [15:0] short_count;
  logic [31:0] last_seq;

  duc_iq_receive #(.PORT(PORT), .SAMPLES(SAMPLES)) dut (
    .rx_clock       (rx_clock),
    .reset          (reset),
    .run            (run),
    .udp_rx_active  (udp_rx_active),
    .udp_rx_data    (udp_rx_data),
    .to_port        (to_port),
    .fifo_full      (fifo_full),
    .fifo_wrreq     (fifo_wrreq),
    .fifo_wdata     (fifo_wdata),
    .seq_error      (seq_error),
    .seq_err_count  (seq_err_count),
    .overflow_count (overflow_count),
    .short_count    (short_count),
    .last_seq       (last_seq)
  );

  initial rx_clock = 1'b0;
  always #5 rx_clock = ~rx_clock;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          err_pulses = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    check("rst_wdata", 64'(fifo_wdata), 64'd0);
    check("rst_seq_error", 64'(seq_error), 64'd0);
    check("rst_seq_err_count", 64'(seq_err_count), 64'd0);
    check("rst_overflow_count", 64'(overflow_count), 64'd0);
    check("rst_short_count", 64'(short_count), 64'd0);
    check("rst_last_seq", 64'(last_seq), 64'd0);
  endtask

  // Monitor: compare every write against the scoreboard, flag back-to-back strobes
  initial begin
    logic wr_prev;
    logic err_prev;
    wr_prev  = 1'b0;
    err_prev = 1'b0;
    forever begin
      @(negedge rx_clock);
      if (!reset) begin
        if (fifo_wrreq) begin
          wr_count++;
          if (exp_q.size() == 0) check("spurious_write", 64'd1, 64'd0);
          else check("fifo_wdata", 64'(fifo_wdata), 64'(exp_q.pop_front()));
          if (wr_prev) check("wrreq_back_to_back", 64'd1, 64'd0);
        end
        if (seq_error) begin
          err_pulses++;
          if (err_prev) check("seq_error_back_to_back", 64'd1, 64'd0);
        end
      end
      wr_prev  = fifo_wrreq;
      err_prev = seq_error;
    end
  end

  // Drive one datagram; fifo_full is held for samples full_lo..full_hi; reset_at>=0 aborts
  task automatic send_dgram(input logic [15:0] port, input logic [31:0] seq, input int nbytes,
                            input int full_lo, input int full_hi, input int reset_at);
    logic [47:0] w;
    logic [7:0]  b;
    bit          accept;
    int          s;
    int          k;
    w = '0;
    accept = run && (port == PORT);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge rx_clock); #1;
      s = 0;
      k = 0;
      if (i < 4) b = seq[8*(3-i) +: 8];
      else begin
        b = 8'($urandom);
        s = (i - 4) / 6;
        k = (i - 4) % 6;
      end
      fifo_full     = (i >= 4) && (s >= full_lo) && (s <= full_hi);
      udp_rx_active = 1'b1;
      udp_rx_data   = b;
      to_port       = port;
      if (i == reset_at) begin
        reset = 1'b1;
        break;
      end
      if (i >= 4) begin
        w = {w[39:0], b};
        if (k == 5 && s < int'(SAMPLES) && accept && !fifo_full) exp_q.push_back(w);
      end
    end
    @(posedge rx_clock); #1;
    reset         = 1'b0;
    udp_rx_active = 1'b0;
    fifo_full     = 1'b0;
    if (reset_at >= 0) begin
      @(negedge rx_clock);
      check_outputs_zero();
    end
    repeat (3) @(posedge rx_clock);
    #2;
  endtask

  task automatic drop_run();
    @(posedge rx_clock); #1;
    run = 1'b0;
    repeat (2) @(posedge rx_clock);
    #1;
    run = 1'b1;
    repeat (2) @(posedge rx_clock);
    #2;
  endtask

  initial begin
    int w0;
    int e0;
    reset         = 1'b1;
    run           = 1'b0;
    udp_rx_active = 1'b0;
    udp_rx_data   = '0;
    to_port       = '0;
    fifo_full     = 1'b0;
    repeat (3) @(posedge rx_clock);
    #2;
    check_outputs_zero();
    reset = 1'b0;
    run   = 1'b1;
    repeat (2) @(posedge rx_clock);
    #2;

    // Two contiguous datagrams; the second carries trailing bytes that must be ignored
    w0 = wr_count;
    e0 = err_pulses;
    send_dgram(PORT, 32'd0, FULL_LEN, -1, -1, -1);
    send_dgram(PORT, 32'd1, FULL_LEN + 6, -1, -1, -1);
    check("t1_writes", 64'(wr_count - w0), 64'd480);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_seq_err_count", 64'(seq_err_count), 64'd0);
    check("t1_err_pulses", 64'(err_pulses - e0), 64'd0);
    check("t1_last_seq", 64'(last_seq), 64'd1);

    // Discontinuity 5 -> 7, then 8 continues from the new value
    drop_run();
    e0 = err_pulses;
    send_dgram(PORT, 32'd5, FULL_LEN, -1, -1, -1);
    send_dgram(PORT, 32'd7, FULL_LEN, -1, -1, -1);
    send_dgram(PORT, 32'd8, FULL_LEN, -1, -1, -1);
    check("t2_err_pulses", 64'(err_pulses - e0), 64'd1);
    check("t2_seq_err_count", 64'(seq_err_count), 64'd1);
    check("t2_last_seq", 64'(last_seq), 64'd8);
    // 32-bit wrap is continuous
    drop_run();
    e0 = err_pulses;
    send_dgram(PORT, 32'hFFFF_FFFF, FULL_LEN, -1, -1, -1);
    send_dgram(PORT, 32'd0, FULL_LEN, -1, -1, -1);
    check("t2_wrap_err_pulses", 64'(err_pulses - e0), 64'd0);
    check("t2_wrap_seq_err_count", 64'(seq_err_count), 64'd1);
    check("t2_wrap_last_seq", 64'(last_seq), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Foreign port and run low produce nothing
    w0 = wr_count;
    send_dgram(16'd1025, 32'd77, FULL_LEN, -1, -1, -1);
    @(posedge rx_clock); #1;
    run = 1'b0;
    send_dgram(PORT, 32'd78, FULL_LEN, -1, -1, -1);
    run = 1'b1;
    repeat (2) @(posedge rx_clock);
    #2;
    check("t3_writes", 64'(wr_count - w0), 64'd0);
    check("t3_seq_err_count", 64'(seq_err_count), 64'd1);
    check("t3_overflow_count", 64'(overflow_count), 64'd0);
    check("t3_short_count", 64'(short_count), 64'd0);
    check("t3_last_seq", 64'(last_seq), 64'd0);

    // FIFO full for samples 10..12 (run low above forced a resync)
    w0 = wr_count;
    e0 = err_pulses;
    send_dgram(PORT, 32'd1, FULL_LEN, 10, 12, -1);
    check("t4_writes", 64'(wr_count - w0), 64'd237);
    check("t4_overflow_count", 64'(overflow_count), 64'd3);
    check("t4_err_pulses", 64'(err_pulses - e0), 64'd0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Truncated after 100 bytes, then a normal datagram
    w0 = wr_count;
    send_dgram(PORT, 32'd2, 100, -1, -1, -1);
    check("t5_short_writes", 64'(wr_count - w0), 64'd16);
    check("t5_short_count", 64'(short_count), 64'd1);
    w0 = wr_count;
    e0 = err_pulses;
    send_dgram(PORT, 32'd3, FULL_LEN, -1, -1, -1);
    check("t5_full_writes", 64'(wr_count - w0), 64'd240);
    check("t5_short_count_hold", 64'(short_count), 64'd1);
    check("t5_err_pulses", 64'(err_pulses - e0), 64'd0);
    check("t5_last_seq", 64'(last_seq), 64'd3);

    // Reset at byte 50, then a datagram with an unrelated sequence number
    send_dgram(PORT, 32'd4, FULL_LEN, -1, -1, 50);
    check("t6_queue_empty_at_reset", 64'(exp_q.size()), 64'd0);
    w0 = wr_count;
    e0 = err_pulses;
    send_dgram(PORT, 32'd100, FULL_LEN, -1, -1, -1);
    check("t6_writes", 64'(wr_count - w0), 64'd240);
    check("t6_err_pulses", 64'(err_pulses - e0), 64'd0);
    check("t6_seq_err_count", 64'(seq_err_count), 64'd0);
    check("t6_last_seq", 64'(last_seq), 64'd100);
    check("t6_short_count", 64'(short_count), 64'd0);
    check("t6_overflow_count", 64'(overflow_count), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
